// File: rtl/wb_port_arbiter_if.sv
// Bundle of the WB-stage, long-latency result and register-file write port
// signals shared between the environment (master) and the arbiter (slave).
interface wb_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  modport master (
    output wb_we, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
    input  ll_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_valid, pend_rd
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
    output ll_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_valid, pend_rd
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: writeback stage has priority, long-latency
// results wait in a one-entry buffer and are drained by a forced stall on starvation.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  logic        r_buf_valid;
  logic [4:0]  r_buf_rd;
  logic [31:0] r_buf_data;
  logic [3:0]  r_cnt;
  logic        r_pipe_stall;

  logic        w_wb_req;
  logic        w_hs;
  logic        w_ll_live;
  logic [3:0]  w_cnt_inc;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  // Writes to x0 are treated as no request; an rd-0 long-latency result is accepted and dropped.
  assign w_wb_req  = io_bus.wb_we && (io_bus.wb_rd != 5'd0);
  assign w_hs      = io_bus.ll_valid && !r_buf_valid;
  assign w_ll_live = w_hs && (io_bus.ll_rd != 5'd0);
  assign w_cnt_inc = r_cnt + 4'd1;

  // Write-port mux driven from the current state and inputs.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 5'd0;
    w_rf_wdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_wb_req) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = io_bus.wb_rd;
          w_rf_wdata = io_bus.wb_data;
        end else if (w_ll_live) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = io_bus.ll_rd;
          w_rf_wdata = io_bus.ll_data;
        end else begin
          w_rf_we    = 1'b0;
          w_rf_waddr = 5'd0;
          w_rf_wdata = 32'd0;
        end
      end
      S_PEND: begin
        if (w_wb_req) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = io_bus.wb_rd;
          w_rf_wdata = io_bus.wb_data;
        end else begin
          w_rf_we    = 1'b1;
          w_rf_waddr = r_buf_rd;
          w_rf_wdata = r_buf_data;
        end
      end
      S_FORCE: begin
        // WB request is ignored here; the stalled pipeline re-presents it.
        w_rf_we    = 1'b1;
        w_rf_waddr = r_buf_rd;
        w_rf_wdata = r_buf_data;
      end
      default: begin
        w_rf_we    = 1'b0;
        w_rf_waddr = 5'd0;
        w_rf_wdata = 32'd0;
      end
    endcase
  end

  // Arbitration FSM, holding buffer and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_buf_valid  <= 1'b0;
      r_buf_rd     <= 5'd0;
      r_buf_data   <= 32'd0;
      r_cnt        <= 4'd0;
      r_pipe_stall <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pipe_stall <= 1'b0;
          // Same-rd WB write is younger, so the long-latency result is simply dropped.
          if (w_ll_live && w_wb_req && (io_bus.ll_rd != io_bus.wb_rd)) begin
            r_buf_valid <= 1'b1;
            r_buf_rd    <= io_bus.ll_rd;
            r_buf_data  <= io_bus.ll_data;
            r_cnt       <= 4'd0;
            r_state     <= S_PEND;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PEND: begin
          if (!w_wb_req || (io_bus.wb_rd == r_buf_rd)) begin
            r_buf_valid  <= 1'b0;
            r_buf_rd     <= 5'd0;
            r_buf_data   <= 32'd0;
            r_cnt        <= 4'd0;
            r_pipe_stall <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == LP_LIMIT) begin
              r_pipe_stall <= 1'b1;
              r_state      <= S_FORCE;
            end else begin
              r_pipe_stall <= 1'b0;
              r_state      <= S_PEND;
            end
          end
        end
        S_FORCE: begin
          r_buf_valid  <= 1'b0;
          r_buf_rd     <= 5'd0;
          r_buf_data   <= 32'd0;
          r_cnt        <= 4'd0;
          r_pipe_stall <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_buf_valid  <= 1'b0;
          r_buf_rd     <= 5'd0;
          r_buf_data   <= 32'd0;
          r_cnt        <= 4'd0;
          r_pipe_stall <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.ll_ready   = !r_buf_valid;
  assign io_bus.rf_we      = w_rf_we;
  assign io_bus.rf_waddr   = w_rf_waddr;
  assign io_bus.rf_wdata   = w_rf_wdata;
  assign io_bus.pipe_stall = r_pipe_stall;
  assign io_bus.pend_valid = r_buf_valid;
  assign io_bus.pend_rd    = r_buf_rd;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations (STARVE_LIMIT=4).
module tb_wb_port_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  wb_port_arbiter_if u_if ();

  wb_port_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    u_if.wb_we   = we;
    u_if.wb_rd   = rd;
    u_if.wb_data = data;
  endtask

  task automatic set_ll(input logic v, input logic [4:0] rd, input logic [31:0] data);
    u_if.ll_valid = v;
    u_if.ll_rd    = rd;
    u_if.ll_data  = data;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, "_we"}, {31'd0, u_if.rf_we}, {31'd0, we});
    check_eq({tag, "_addr"}, {27'd0, u_if.rf_waddr}, {27'd0, a});
    check_eq({tag, "_data"}, u_if.rf_wdata, d);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    set_ll(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check_rf("rst_rf", 1'b0, 5'd0, 32'd0);
    check_eq("rst_ll_ready", {31'd0, u_if.ll_ready}, 32'd1);
    check_eq("rst_stall", {31'd0, u_if.pipe_stall}, 32'd0);
    check_eq("rst_pend_valid", {31'd0, u_if.pend_valid}, 32'd0);
    check_eq("rst_pend_rd", {27'd0, u_if.pend_rd}, 32'd0);

    // Plain WB write passes straight through
    set_wb(1'b1, 5'd5, 32'h11);
    #1;
    check_rf("wb5", 1'b1, 5'd5, 32'h11);
    check_eq("wb5_ll_ready", {31'd0, u_if.ll_ready}, 32'd1);
    tick();

    // Direct long-latency write while WB is idle
    set_wb(1'b0, 5'd0, 32'd0);
    set_ll(1'b1, 5'd7, 32'hAB);
    #1;
    check_rf("ll7", 1'b1, 5'd7, 32'hAB);
    tick();
    set_ll(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("ll7_pend", {31'd0, u_if.pend_valid}, 32'd0);
    check_rf("ll7_after", 1'b0, 5'd0, 32'd0);
    tick();

    // Starvation: WB hogs the port, buffered rd 9 is forced out after 4 lost cycles
    set_wb(1'b1, 5'd3, 32'h33);
    set_ll(1'b1, 5'd9, 32'hCD);
    #1;
    check_rf("cap9", 1'b1, 5'd3, 32'h33);
    tick();
    set_ll(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_rf($sformatf("starve%0d", i), 1'b1, 5'd3, 32'h33);
      check_eq($sformatf("starve%0d_stall", i), {31'd0, u_if.pipe_stall}, 32'd0);
      check_eq($sformatf("starve%0d_pend_rd", i), {27'd0, u_if.pend_rd}, 32'd9);
      check_eq($sformatf("starve%0d_ll_ready", i), {31'd0, u_if.ll_ready}, 32'd0);
      tick();
    end
    #1;
    check_eq("force_stall", {31'd0, u_if.pipe_stall}, 32'd1);
    check_rf("force", 1'b1, 5'd9, 32'hCD);
    tick();
    #1;
    check_eq("post_force_stall", {31'd0, u_if.pipe_stall}, 32'd0);
    check_eq("post_force_pend", {31'd0, u_if.pend_valid}, 32'd0);
    check_eq("post_force_ll_ready", {31'd0, u_if.ll_ready}, 32'd1);
    check_rf("post_force", 1'b1, 5'd3, 32'h33);
    tick();

    // Buffered rd 9 discarded by a younger WB write to rd 9
    set_wb(1'b1, 5'd3, 32'h33);
    set_ll(1'b1, 5'd9, 32'hCD);
    tick();
    set_ll(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd9, 32'h22);
    #1;
    check_rf("waw9", 1'b1, 5'd9, 32'h22);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("waw9_pend", {31'd0, u_if.pend_valid}, 32'd0);
    check_rf("waw9_after", 1'b0, 5'd0, 32'd0);
    tick();

    // Same-cycle WAW in IDLE: long-latency result dropped, never buffered
    set_wb(1'b1, 5'd4, 32'h44);
    set_ll(1'b1, 5'd4, 32'h55);
    #1;
    check_rf("idle_waw", 1'b1, 5'd4, 32'h44);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    set_ll(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("idle_waw_pend", {31'd0, u_if.pend_valid}, 32'd0);
    check_rf("idle_waw_after", 1'b0, 5'd0, 32'd0);
    tick();

    // rd 0 long-latency result: handshaken, no write
    set_ll(1'b1, 5'd0, 32'hEE);
    #1;
    check_eq("rd0_ready", {31'd0, u_if.ll_ready}, 32'd1);
    check_rf("rd0", 1'b0, 5'd0, 32'd0);
    tick();
    set_ll(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("rd0_pend", {31'd0, u_if.pend_valid}, 32'd0);
    tick();

    // Buffer drains on the first WB-idle cycle
    set_wb(1'b1, 5'd3, 32'h33);
    set_ll(1'b1, 5'd10, 32'h5A);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    set_ll(1'b0, 5'd0, 32'd0);
    #1;
    check_rf("drain10", 1'b1, 5'd10, 32'h5A);
    check_eq("drain10_stall", {31'd0, u_if.pipe_stall}, 32'd0);
    tick();
    #1;
    check_eq("drain10_pend", {31'd0, u_if.pend_valid}, 32'd0);
    check_rf("drain10_after", 1'b0, 5'd0, 32'd0);
    tick();

    // Reset while PEND loses the buffered entry
    set_wb(1'b1, 5'd3, 32'h33);
    set_ll(1'b1, 5'd12, 32'h77);
    tick();
    set_ll(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("pre_rst_pend", {31'd0, u_if.pend_valid}, 32'd1);
    check_eq("pre_rst_pend_rd", {27'd0, u_if.pend_rd}, 32'd12);
    reset = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_pend", {31'd0, u_if.pend_valid}, 32'd0);
    check_eq("mid_rst_pend_rd", {27'd0, u_if.pend_rd}, 32'd0);
    check_eq("mid_rst_ll_ready", {31'd0, u_if.ll_ready}, 32'd1);
    check_rf("mid_rst", 1'b0, 5'd0, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
